if_fetch_queue: RTL and testbench

- Parametrised successor to the current IF response path. The current path has a single-entry instruction buffer and a 1-bit cancel flag. This block replaces them with an N-entry response FIFO, a multi-outstanding PC tracker and a counted cancel mechanism.
- Sits between pre-IF/ICache request issue and ID.
- Accepts in-order fetch responses of FETCH_W instructions each. Discards responses to requests killed by a flush. Presents one fetch group per cycle to ID under a valid/allowin handshake.

---
 rtl/if_fetch_queue.sv | 141 ++++++++++++++
 tb/tb_if_fetch_queue.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_queue
// Brief    : IF response FIFO with multi-outstanding PC tracker and counted
//            cancellation of responses belonging to flushed requests.
// Revision : 1.0
// ============================================================================
module if_fetch_queue #(
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4,
  parameter int FETCH_W         = 2,
  parameter int PC_W            = 32,
  parameter int INST_W          = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid_i,
  input  logic [PC_W-1:0]                      req_pc_i,
  output logic                                 req_ready_o,
  input  logic                                 resp_data_ok_i,
  input  logic [FETCH_W*INST_W-1:0]            resp_rdata_i,
  input  logic                                 resp_excp_i,
  input  logic                                 flush_i,
  input  logic                                 next_allowin_i,
  output logic                                 out_valid_o,
  output logic [PC_W-1:0]                      out_pc_o,
  output logic [FETCH_W*INST_W-1:0]            out_inst_o,
  output logic [FETCH_W-1:0]                   out_mask_o,
  output logic                                 out_excp_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     inflight_cnt_o,
  output logic [$clog2(MAX_OUTSTANDING):0]     cancel_cnt_o
);

  localparam int c_PTR_W  = $clog2(DEPTH);
  localparam int c_TRK_W  = $clog2(MAX_OUTSTANDING);
  localparam int c_CNT_W  = $clog2(MAX_OUTSTANDING) + 1;
  localparam int c_DATA_W = FETCH_W * INST_W;

  logic [PC_W-1:0]     r_fifo_pc   [DEPTH];
  logic [c_DATA_W-1:0] r_fifo_inst [DEPTH];
  logic                r_fifo_excp [DEPTH];
  logic [FETCH_W-1:0]  r_fifo_mask [DEPTH];
  logic [c_PTR_W:0]    r_fifo_wr;
  logic [c_PTR_W:0]    r_fifo_rd;

  logic [PC_W-1:0]     r_trk_pc [MAX_OUTSTANDING];
  logic [c_TRK_W:0]    r_trk_wr;
  logic [c_TRK_W:0]    r_trk_rd;

  logic [c_CNT_W-1:0]  r_inflight;
  logic [c_CNT_W-1:0]  r_cancel;

  logic [c_PTR_W:0]    w_fifo_count;
  logic                w_fifo_empty;
  logic                w_accept;
  logic                w_resp_drop;
  logic                w_resp_take;
  logic                w_push;
  logic                w_pop;
  logic [PC_W-1:0]     w_trk_head_pc;
  logic [FETCH_W-1:0]  w_mask;

  assign w_fifo_count  = r_fifo_wr - r_fifo_rd;
  assign w_fifo_empty  = (r_fifo_wr == r_fifo_rd);
  assign w_trk_head_pc = r_trk_pc[r_trk_rd[c_TRK_W-1:0]];

  // Credit check reserves a FIFO slot per in-flight request, so pushes never stall.
  assign req_ready_o = !rst && !flush_i
                    && ((32'(r_inflight) + 32'(r_cancel)) < 32'(MAX_OUTSTANDING))
                    && ((32'(r_inflight) + 32'(w_fifo_count)) < 32'(DEPTH));

  assign w_accept    = req_valid_i && req_ready_o;
  assign w_resp_drop = resp_data_ok_i && (r_cancel != '0);
  assign w_resp_take = resp_data_ok_i && (r_cancel == '0) && (r_inflight != '0);
  assign w_push      = w_resp_take && !flush_i;
  assign w_pop       = out_valid_o && next_allowin_i && !flush_i;

  generate
    if (FETCH_W == 1) begin : g_mask_single
      assign w_mask = 1'b1;
    end else begin : g_mask_multi
      localparam int c_OFF_W = $clog2(FETCH_W);
      logic [c_OFF_W-1:0] w_off;
      assign w_off = w_trk_head_pc[c_OFF_W+1:2];
      for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
        assign w_mask[k] = resp_excp_i ? (c_OFF_W'(k) == w_off)
                                       : (c_OFF_W'(k) >= w_off);
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_trk_pc[r_trk_wr[c_TRK_W-1:0]] <= req_pc_i;
    end
    if (w_push) begin
      r_fifo_pc  [r_fifo_wr[c_PTR_W-1:0]] <= w_trk_head_pc;
      r_fifo_inst[r_fifo_wr[c_PTR_W-1:0]] <= resp_rdata_i;
      r_fifo_excp[r_fifo_wr[c_PTR_W-1:0]] <= resp_excp_i;
      r_fifo_mask[r_fifo_wr[c_PTR_W-1:0]] <= w_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_trk_wr   <= '0;
      r_trk_rd   <= '0;
      r_inflight <= '0;
      r_cancel   <= '0;
    end else if (flush_i) begin
      // Everything still in flight becomes a pending discard; a response
      // landing in this same cycle consumes one of those discards.
      r_fifo_wr  <= '0;
      r_fifo_rd  <= '0;
      r_trk_wr   <= '0;
      r_trk_rd   <= '0;
      r_inflight <= '0;
      r_cancel   <= r_cancel + r_inflight - c_CNT_W'(resp_data_ok_i);
    end else begin
      if (w_accept)    r_trk_wr  <= r_trk_wr + 1'b1;
      if (w_resp_take) r_trk_rd  <= r_trk_rd + 1'b1;
      if (w_push)      r_fifo_wr <= r_fifo_wr + 1'b1;
      if (w_pop)       r_fifo_rd <= r_fifo_rd + 1'b1;
      r_inflight <= r_inflight + c_CNT_W'(w_accept) - c_CNT_W'(w_resp_take);
      r_cancel   <= r_cancel - c_CNT_W'(w_resp_drop);
    end
  end

  // Entry storage is not reset, so the head is gated to zero when empty.
  assign out_valid_o    = !w_fifo_empty;
  assign out_pc_o       = out_valid_o ? r_fifo_pc  [r_fifo_rd[c_PTR_W-1:0]] : '0;
  assign out_inst_o     = out_valid_o ? r_fifo_inst[r_fifo_rd[c_PTR_W-1:0]] : '0;
  assign out_mask_o     = out_valid_o ? r_fifo_mask[r_fifo_rd[c_PTR_W-1:0]] : '0;
  assign out_excp_o     = out_valid_o && r_fifo_excp[r_fifo_rd[c_PTR_W-1:0]];
  assign inflight_cnt_o = r_inflight;
  assign cancel_cnt_o   = r_cancel;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_queue
// Brief    : Directed table-driven bench for if_fetch_queue (default params).
// Revision : 1.0
// ============================================================================
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i;
  logic [31:0] req_pc_i;
  logic        req_ready_o;
  logic        resp_data_ok_i;
  logic [63:0] resp_rdata_i;
  logic        resp_excp_i;
  logic        flush_i;
  logic        next_allowin_i;
  logic        out_valid_o;
  logic [31:0] out_pc_o;
  logic [63:0] out_inst_o;
  logic [1:0]  out_mask_o;
  logic        out_excp_o;
  logic [2:0]  inflight_cnt_o;
  logic [2:0]  cancel_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(
    .DEPTH(4), .MAX_OUTSTANDING(4), .FETCH_W(2), .PC_W(32), .INST_W(32)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_pc_i(req_pc_i), .req_ready_o(req_ready_o),
    .resp_data_ok_i(resp_data_ok_i), .resp_rdata_i(resp_rdata_i),
    .resp_excp_i(resp_excp_i), .flush_i(flush_i), .next_allowin_i(next_allowin_i),
    .out_valid_o(out_valid_o), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_mask_o(out_mask_o), .out_excp_o(out_excp_o),
    .inflight_cnt_o(inflight_cnt_o), .cancel_cnt_o(cancel_cnt_o)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] pc;
    logic        rok;
    logic [31:0] rpc;
    logic        excp;
    logic        flush;
    logic        alw;
    logic        rdy;
    logic        ov;
    logic [31:0] opc;
    logic [1:0]  omask;
    logic        oexc;
    logic [2:0]  infl;
    logic [2:0]  canc;
  } vec_t;

  vec_t tbl[$];

  localparam logic [31:0] c_P = 32'h1c00_0000;

  function automatic logic [63:0] gdata(input logic [31:0] pc);
    return {pc ^ 32'hA5A5_5A5A, pc};
  endfunction

  function automatic vec_t v(input logic r, input logic rv, input logic [31:0] pc,
                             input logic rok, input logic [31:0] rpc, input logic ex,
                             input logic fl, input logic alw, input logic rdy,
                             input logic ov, input logic [31:0] opc, input logic [1:0] om,
                             input logic oe, input logic [2:0] inf, input logic [2:0] cn);
    vec_t t;
    t.rst = r; t.rv = rv; t.pc = pc; t.rok = rok; t.rpc = rpc; t.excp = ex;
    t.flush = fl; t.alw = alw; t.rdy = rdy; t.ov = ov; t.opc = opc;
    t.omask = om; t.oexc = oe; t.infl = inf; t.canc = cn;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int row);
    @(negedge clk);
    rst = t.rst; req_valid_i = t.rv; req_pc_i = t.pc;
    resp_data_ok_i = t.rok; resp_rdata_i = gdata(t.rpc); resp_excp_i = t.excp;
    flush_i = t.flush; next_allowin_i = t.alw;
    #1;
    chk("req_ready", row, 64'(req_ready_o), 64'(t.rdy));
    @(posedge clk);
    #1;
    chk("out_valid", row, 64'(out_valid_o), 64'(t.ov));
    chk("out_pc",    row, 64'(out_pc_o),    64'(t.opc));
    chk("out_inst",  row, out_inst_o,       t.ov ? gdata(t.opc) : 64'h0);
    chk("out_mask",  row, 64'(out_mask_o),  64'(t.omask));
    chk("out_excp",  row, 64'(out_excp_o),  64'(t.oexc));
    chk("inflight",  row, 64'(inflight_cnt_o), 64'(t.infl));
    chk("cancel",    row, 64'(cancel_cnt_o),   64'(t.canc));
  endtask

  // A response with nothing tracked and nothing to cancel is illegal stimulus.
  always @(negedge clk) begin
    #1;
    if (rst === 1'b0 && resp_data_ok_i === 1'b1 &&
        cancel_cnt_o == 3'd0 && inflight_cnt_o == 3'd0) begin
      errors++;
      $display("FAIL illegal_resp: data_ok with inflight=0 cancel=0 at %0t", $time);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    bit found;
    rst = 1'b1; req_valid_i = 0; req_pc_i = 0; resp_data_ok_i = 0;
    resp_rdata_i = 0; resp_excp_i = 0; flush_i = 0; next_allowin_i = 0;

    //              rst rv pc        rok rpc       ex fl al  rdy ov opc       msk oe inf cn
    // reset and streaming
    tbl.push_back(v(1, 0, 0,         0, 0,         0, 0, 0,  0, 0, 0,         0, 0, 0, 0));
    tbl.push_back(v(0, 1, c_P,       0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+8,     1, c_P,       0, 0, 1,  1, 1, c_P,       3, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+'h10,  1, c_P+8,     0, 0, 1,  1, 1, c_P+8,     3, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h10,  0, 0, 1,  1, 1, c_P+'h10,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    // full FIFO with ID stalled
    tbl.push_back(v(0, 1, c_P+'h20,  0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+'h28,  0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 2, 0));
    tbl.push_back(v(0, 1, c_P+'h30,  0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 3, 0));
    tbl.push_back(v(0, 1, c_P+'h38,  0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 4, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h20,  0, 0, 0,  0, 1, c_P+'h20,  3, 0, 3, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h28,  0, 0, 0,  0, 1, c_P+'h20,  3, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h30,  0, 0, 0,  0, 1, c_P+'h20,  3, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h38,  0, 0, 0,  0, 1, c_P+'h20,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 0,  0, 1, c_P+'h20,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  0, 1, c_P+'h28,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 1, c_P+'h30,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 1, c_P+'h38,  3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    // flush with three outstanding
    tbl.push_back(v(0, 1, c_P+'h40,  0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+'h48,  0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 2, 0));
    tbl.push_back(v(0, 1, c_P+'h50,  0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 3, 0));
    tbl.push_back(v(0, 1, c_P+'h58,  0, 0,         0, 1, 1,  0, 0, 0,         0, 0, 0, 3));
    tbl.push_back(v(0, 1, c_P+'h100, 1, 32'hdead0, 0, 0, 0,  1, 0, 0,         0, 0, 1, 2));
    tbl.push_back(v(0, 0, 0,         1, 32'hdead1, 0, 0, 0,  1, 0, 0,         0, 0, 1, 1));
    tbl.push_back(v(0, 0, 0,         1, 32'hdead2, 0, 0, 0,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h100, 0, 0, 0,  1, 1, c_P+'h100, 3, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    // flush coinciding with data_ok
    tbl.push_back(v(0, 1, c_P+'h200, 0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+'h208, 0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 2, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h200, 0, 1, 1,  0, 0, 0,         0, 0, 0, 1));
    tbl.push_back(v(0, 0, 0,         1, c_P+'h208, 0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    // misaligned PC and exception masks
    tbl.push_back(v(0, 1, c_P+4,     0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+4,     1, c_P+4,     0, 0, 0,  1, 1, c_P+4,     2, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P+4,     1, 0, 1,  1, 1, c_P+4,     2, 1, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    tbl.push_back(v(0, 1, c_P,       0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 0, 0,         1, c_P,       1, 0, 0,  1, 1, c_P,       1, 1, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 1,  1, 0, 0,         0, 0, 0, 0));
    // reset mid-stream
    tbl.push_back(v(0, 1, c_P+'h300, 0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 1, 0));
    tbl.push_back(v(0, 1, c_P+'h308, 0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 2, 0));
    tbl.push_back(v(0, 1, c_P+'h310, 1, c_P+'h300, 0, 0, 0,  1, 1, c_P+'h300, 3, 0, 2, 0));
    tbl.push_back(v(0, 1, c_P+'h318, 1, c_P+'h308, 0, 0, 0,  1, 1, c_P+'h300, 3, 0, 2, 0));
    tbl.push_back(v(1, 0, 0,         0, 0,         0, 0, 0,  0, 0, 0,         0, 0, 0, 0));
    tbl.push_back(v(0, 0, 0,         0, 0,         0, 0, 0,  1, 0, 0,         0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // Back-to-back flushes: cancel count saturates at the outstanding limit
    for (int i = 0; i < 4; i++)
      run_vec(v(0, 1, c_P+'h400+32'(8*i), 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3'(i+1), 0), 100+i);
    run_vec(v(0, 0, 0, 0, 0,          0, 1, 1, 0, 0, 0, 0, 0, 0, 4), 104);
    run_vec(v(0, 0, 0, 1, 32'hdead3,  0, 1, 1, 0, 0, 0, 0, 0, 0, 3), 105);
    run_vec(v(0, 0, 0, 0, 0,          0, 1, 1, 0, 0, 0, 0, 0, 0, 3), 106);
    run_vec(v(0, 0, 0, 1, 32'hdead4,  0, 0, 1, 1, 0, 0, 0, 0, 0, 2), 107);
    run_vec(v(0, 0, 0, 1, 32'hdead5,  0, 0, 1, 1, 0, 0, 0, 0, 0, 1), 108);
    run_vec(v(0, 0, 0, 1, 32'hdead6,  0, 0, 1, 1, 0, 0, 0, 0, 0, 0), 109);
    run_vec(v(0, 1, c_P+'h500, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1, 0), 110);

    // Single response after the drain, waiting a bounded number of cycles
    @(negedge clk);
    req_valid_i = 0; resp_data_ok_i = 1; resp_rdata_i = gdata(c_P+'h500);
    resp_excp_i = 0; flush_i = 0; next_allowin_i = 0;
    @(negedge clk);
    resp_data_ok_i = 0;
    found = 1'b0;
    for (int n = 0; n < 6 && !found; n++) begin
      if (out_valid_o) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("wait_valid", 200, 64'(found), 64'd1);
    chk("wait_pc",    200, 64'(out_pc_o), 64'(c_P+'h500));
    chk("wait_infl",  200, 64'(inflight_cnt_o), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
